// File: rtl/tqv_reg_arbiter.sv
// Two-requester arbiter for the byte peripheral's single register port.
// Each access takes three cycles: IDLE (select), ISSUE (drive port, capture data), COMPLETE (ack).
module tqv_reg_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] per_address,
  output logic [DATA_W-1:0] per_data_in,
  output logic              per_data_write,
  input  logic [DATA_W-1:0] per_data_out,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick_r1;

  // Winner selection; ptr_q = 1 means requester 1 is favoured on a tie.
  always_comb begin
    pick_r1 = 1'b0;
    if (r0_req && r1_req) begin
      if (FIXED_PRIO != 0) begin
        pick_r1 = 1'b0;
      end else begin
        pick_r1 = ptr_q;
      end
    end else if (r1_req) begin
      pick_r1 = 1'b1;
    end else begin
      pick_r1 = 1'b0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          state_d = ST_ISSUE;
          busy_d  = 1'b1;
          grant_d = pick_r1 ? 2'b10 : 2'b01;
          addr_d  = pick_r1 ? r1_addr : r0_addr;
          wdata_d = pick_r1 ? r1_wdata : r0_wdata;
          write_d = pick_r1 ? r1_we : r0_we;
        end else begin
          busy_d  = 1'b0;
          grant_d = 2'b00;
        end
      end
      ST_ISSUE: begin
        // Peripheral data is sampled for writes as well, giving a readback.
        state_d = ST_COMPLETE;
        busy_d  = 1'b1;
        if (grant_q[1]) begin
          rdata1_d = per_data_out;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = per_data_out;
          ack0_d   = 1'b1;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        grant_d = 2'b00;
        ptr_d   = grant_q[0];
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        grant_d = 2'b00;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      grant_q  <= 2'b00;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign per_address    = addr_q;
  assign per_data_in    = wdata_q;
  assign per_data_write = write_q;
  assign grant          = grant_q;
  assign busy           = busy_q;
  assign r0_ack         = ack0_q;
  assign r1_ack         = ack1_q;
  assign r0_rdata       = rdata0_q;
  assign r1_rdata       = rdata1_q;

endmodule

// File: tb/tb_tqv_reg_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter, each with its own peripheral
// register file, checked against a transaction-level reference model.
module tb_tqv_reg_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index [d][r]: d = 0 round-robin arbiter, d = 1 fixed-priority arbiter
  logic          req_s   [2][2];
  logic          we_s    [2][2];
  logic [AW-1:0] addr_s  [2][2];
  logic [DW-1:0] wdata_s [2][2];
  logic          ack_s   [2][2];
  logic [DW-1:0] rdata_s [2][2];
  logic [AW-1:0] pa_s  [2];
  logic [DW-1:0] pdi_s [2];
  logic          pw_s  [2];
  logic [DW-1:0] pdo_s [2];
  logic [1:0]    grant_s [2];
  logic          busy_s  [2];

  tqv_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .r0_req(req_s[0][0]), .r0_we(we_s[0][0]), .r0_addr(addr_s[0][0]), .r0_wdata(wdata_s[0][0]),
    .r0_ack(ack_s[0][0]), .r0_rdata(rdata_s[0][0]),
    .r1_req(req_s[0][1]), .r1_we(we_s[0][1]), .r1_addr(addr_s[0][1]), .r1_wdata(wdata_s[0][1]),
    .r1_ack(ack_s[0][1]), .r1_rdata(rdata_s[0][1]),
    .per_address(pa_s[0]), .per_data_in(pdi_s[0]), .per_data_write(pw_s[0]),
    .per_data_out(pdo_s[0]), .grant(grant_s[0]), .busy(busy_s[0])
  );

  tqv_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .r0_req(req_s[1][0]), .r0_we(we_s[1][0]), .r0_addr(addr_s[1][0]), .r0_wdata(wdata_s[1][0]),
    .r0_ack(ack_s[1][0]), .r0_rdata(rdata_s[1][0]),
    .r1_req(req_s[1][1]), .r1_we(we_s[1][1]), .r1_addr(addr_s[1][1]), .r1_wdata(wdata_s[1][1]),
    .r1_ack(ack_s[1][1]), .r1_rdata(rdata_s[1][1]),
    .per_address(pa_s[1]), .per_data_in(pdi_s[1]), .per_data_write(pw_s[1]),
    .per_data_out(pdo_s[1]), .grant(grant_s[1]), .busy(busy_s[1])
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 7) return 8'h5C;
    return 8'(i * 37 + 11);
  endfunction

  // Peripheral register files: combinational read, write on the strobe edge.
  logic [DW-1:0] pmem [2][16];
  assign pdo_s[0] = pmem[0][pa_s[0]];
  assign pdo_s[1] = pmem[1][pa_s[1]];
  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) pmem[d][i] = init_val(i);
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) if (pw_s[d]) pmem[d][pa_s[d]] <= pdi_s[d];
    end
  end

  // Reference model: one transaction per arbiter, three clock edges each.
  typedef struct {
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            ack_cyc;
  } txn_t;

  txn_t          iss_q [2][$];
  txn_t          ack_q [2][$];
  int            who_log [2][$];
  int            cyc_log [2][$];

  initial begin
    logic [DW-1:0] rmem [2][16];
    txn_t cur [2];
    int   remain [2];
    int   prefer [2];
    int   w;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) rmem[d][i] = init_val(i);
      remain[d] = 0;
      prefer[d] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          remain[d] = 0;
          prefer[d] = 0;
          iss_q[d].delete();
          ack_q[d].delete();
        end else if (remain[d] == 2) begin
          cur[d].rdata = rmem[d][cur[d].addr];
          if (cur[d].we) rmem[d][cur[d].addr] = cur[d].wdata;
          ack_q[d].push_back(cur[d]);
          remain[d] = 1;
        end else if (remain[d] == 1) begin
          prefer[d] = 1 - cur[d].who;
          remain[d] = 0;
        end else if (req_s[d][0] || req_s[d][1]) begin
          if (req_s[d][0] && req_s[d][1]) w = (d == 1) ? 0 : prefer[d];
          else w = req_s[d][1] ? 1 : 0;
          cur[d].who     = w;
          cur[d].we      = we_s[d][w];
          cur[d].addr    = addr_s[d][w];
          cur[d].wdata   = wdata_s[d][w];
          cur[d].rdata   = '0;
          cur[d].ack_cyc = cyc + 2;
          iss_q[d].push_back(cur[d]);
          remain[d] = 2;
        end
      end
    end
  end

  // Monitor: compares whatever each arbiter presents against the scoreboard.
  initial begin
    logic prev_pw [2];
    txn_t t;
    prev_pw[0] = 1'b0;
    prev_pw[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          prev_pw[d] = 1'b0;
        end else begin
          chk($sformatf("pw_not_twice d%0d", d), prev_pw[d] & pw_s[d], 0);
          chk($sformatf("single_ack d%0d", d), ack_s[d][0] & ack_s[d][1], 0);
          prev_pw[d] = pw_s[d];
          if (ack_s[d][0] || ack_s[d][1]) begin
            if (ack_q[d].size() == 0) begin
              chk($sformatf("unexpected_ack d%0d", d), ack_s[d][0] | ack_s[d][1], 0);
            end else begin
              t = ack_q[d].pop_front();
              chk($sformatf("ack_owner d%0d", d), ack_s[d][t.who], 1);
              chk($sformatf("rdata d%0d r%0d", d, t.who), rdata_s[d][t.who], t.rdata);
              chk($sformatf("ack_cycle d%0d", d), cyc, t.ack_cyc);
              chk($sformatf("grant_complete d%0d", d), grant_s[d], (t.who == 1) ? 32'd2 : 32'd1);
              chk($sformatf("busy_complete d%0d", d), busy_s[d], 1);
              chk($sformatf("pw_complete d%0d", d), pw_s[d], 0);
              who_log[d].push_back(t.who);
              cyc_log[d].push_back(cyc);
            end
          end else begin
            if (ack_q[d].size() != 0) begin
              t = ack_q[d].pop_front();
              chk($sformatf("ack_present d%0d", d), ack_s[d][t.who], 1);
            end
            if (busy_s[d]) begin
              if (iss_q[d].size() == 0) begin
                chk($sformatf("unexpected_issue d%0d", d), busy_s[d], 0);
              end else begin
                t = iss_q[d].pop_front();
                chk($sformatf("per_address d%0d", d), pa_s[d], t.addr);
                chk($sformatf("per_data_in d%0d", d), pdi_s[d], t.wdata);
                chk($sformatf("per_data_write d%0d", d), pw_s[d], t.we);
                chk($sformatf("grant_issue d%0d", d), grant_s[d], (t.who == 1) ? 32'd2 : 32'd1);
              end
            end else begin
              if (iss_q[d].size() != 0) begin
                t = iss_q[d].pop_front();
                chk($sformatf("issue_present d%0d", d), busy_s[d], 1);
              end
              chk($sformatf("grant_idle d%0d", d), grant_s[d], 0);
              chk($sformatf("pw_idle d%0d", d), pw_s[d], 0);
            end
          end
        end
      end
    end
  end

  // mode: 0 manual, 1 random, 2 always re-request, 3 drain (drop after ack)
  int mode [2];

  task automatic new_cmd(input int d, input int r);
    we_s[d][r]    = 1'($urandom_range(0, 1));
    addr_s[d][r]  = 4'($urandom_range(0, 15));
    wdata_s[d][r] = 8'($urandom_range(0, 255));
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) begin
      if (mode[d] != 0) begin
        if (req_s[d][r]) begin
          if (ack_s[d][r]) begin
            if (mode[d] == 2 || (mode[d] == 1 && $urandom_range(0, 1) == 1)) new_cmd(d, r);
            else req_s[d][r] = 1'b0;
          end else if (mode[d] == 1 && grant_s[d][r] && $urandom_range(0, 1) == 1) begin
            new_cmd(d, r);
          end
        end else if (mode[d] == 2 || (mode[d] == 1 && $urandom_range(0, 2) == 0)) begin
          req_s[d][r] = 1'b1;
          new_cmd(d, r);
        end
      end
    end
  endtask

  task automatic drain();
    int i;
    mode[0] = 3;
    mode[1] = 3;
    i = 0;
    while (i < 60 && (req_s[0][0] || req_s[0][1] || req_s[1][0] || req_s[1][1] || busy_s[0] || busy_s[1])) begin
      step();
      i++;
    end
    chk("drain_done", i < 60, 1);
    mode[0] = 0;
    mode[1] = 0;
  endtask

  task automatic do_txn(input int d, input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    int n;
    @(negedge clk);
    req_s[d][r]   = 1'b1;
    we_s[d][r]    = we;
    addr_s[d][r]  = a;
    wdata_s[d][r] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_s[d][r] && n < 8);
    chk($sformatf("ack_latency d%0d r%0d", d, r), n, 2);
    req_s[d][r] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old_v;
    int n;
    int ones;
    mode[0] = 0;
    mode[1] = 0;
    for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) begin
      req_s[d][r] = 1'b0; we_s[d][r] = 1'b0; addr_s[d][r] = '0; wdata_s[d][r] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst grant d%0d", d), grant_s[d], 0);
      chk($sformatf("rst busy d%0d", d), busy_s[d], 0);
      chk($sformatf("rst pw d%0d", d), pw_s[d], 0);
      chk($sformatf("rst pa d%0d", d), pa_s[d], 0);
      chk($sformatf("rst pdi d%0d", d), pdi_s[d], 0);
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("rst ack d%0d r%0d", d, r), ack_s[d][r], 0);
        chk($sformatf("rst rdata d%0d r%0d", d, r), rdata_s[d][r], 0);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write by r0, then single read by r1, on both arbiters.
    for (int d = 0; d < 2; d++) begin
      do_txn(d, 0, 1'b1, 4'h3, 8'hA5);
      chk($sformatf("wr commit d%0d", d), pmem[d][3], 8'hA5);
    end
    for (int d = 0; d < 2; d++) begin
      do_txn(d, 1, 1'b0, 4'h7, 8'h00);
      chk($sformatf("rd data d%0d", d), rdata_s[d][1], 8'h5C);
    end

    // Both requesters held high: alternation vs fixed priority.
    for (int d = 0; d < 2; d++) begin
      who_log[d].delete();
      cyc_log[d].delete();
      mode[d] = 2;
    end
    n = 0;
    while (n < 80 && (who_log[0].size() < 6 || who_log[1].size() < 6)) begin
      step();
      n++;
    end
    chk("hold_count rr", who_log[0].size() >= 6, 1);
    chk("hold_count fp", who_log[1].size() >= 6, 1);
    if (who_log[0].size() >= 6 && who_log[1].size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("rr winner %0d", i), who_log[0][i], i % 2);
        chk($sformatf("fp winner %0d", i), who_log[1][i], 0);
        if (i > 0) begin
          chk($sformatf("rr spacing %0d", i), cyc_log[0][i] - cyc_log[0][i-1], 3);
          chk($sformatf("fp spacing %0d", i), cyc_log[1][i] - cyc_log[1][i-1], 3);
        end
      end
    end
    drain();
    ones = 0;
    foreach (who_log[1][i]) ones += who_log[1][i];
    chk("fp r1 served once", ones, 1);
    chk("fp r1 served last", who_log[1][who_log[1].size()-1], 1);

    // r0 drops req and changes address during ISSUE: original write still commits.
    old_v = pmem[0][2];
    @(negedge clk);
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 4'h9; wdata_s[0][0] = 8'h3C;
    @(negedge clk);
    chk("drop issue seen", busy_s[0], 1);
    req_s[0][0] = 1'b0; we_s[0][0] = 1'b0; addr_s[0][0] = 4'h2; wdata_s[0][0] = 8'hFF;
    n = 0;
    while (!ack_s[0][0] && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("drop ack", ack_s[0][0], 1);
    chk("drop commit addr9", pmem[0][9], 8'h3C);
    chk("drop untouched addr2", pmem[0][2], old_v);

    // Randomized traffic on both arbiters.
    mode[0] = 1;
    mode[1] = 1;
    repeat (300) step();
    drain();

    // Reset during ISSUE: strobe lost, no ack, pointer back to r0.
    do_txn(0, 0, 1'b0, 4'h1, 8'h00);
    old_v = pmem[0][5];
    @(negedge clk);
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 4'h5; wdata_s[0][0] = ~old_v;
    @(negedge clk);
    chk("pre-reset busy", busy_s[0], 1);
    chk("pre-reset pw", pw_s[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset pw", pw_s[0], 0);
    chk("reset grant", grant_s[0], 0);
    chk("reset busy", busy_s[0], 0);
    chk("reset ack0", ack_s[0][0], 0);
    chk("reset ack1", ack_s[0][1], 0);
    req_s[0][0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset write lost", pmem[0][5], old_v);
    rst_n = 1'b1;
    @(negedge clk);
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 4'h1;
    req_s[0][1] = 1'b1; we_s[0][1] = 1'b0; addr_s[0][1] = 4'h2;
    n = 0;
    while (!(ack_s[0][0] || ack_s[0][1]) && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("post-reset r0 first", ack_s[0][0], 1);
    chk("post-reset r1 waits", ack_s[0][1], 0);
    req_s[0][0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_s[0][1] && n < 6);
    chk("post-reset r1 ack", ack_s[0][1], 1);
    req_s[0][1] = 1'b0;
    repeat (4) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("issue queue empty d%0d", d), iss_q[d].size(), 0);
      chk($sformatf("ack queue empty d%0d", d), ack_q[d].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
